// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sizing defaults and the writeback-priority state encoding.
// Also used by the register file and the hazard unit.
package regfile_pkg;

    localparam int REG_SIZE     = 16;
    localparam int ADDR_W       = 4;
    localparam int REG_NUMBER   = 8;
    localparam int STARVE_LIMIT = 3;

    typedef enum logic {
        PRIO1 = 1'b0,
        PRIO0 = 1'b1
    } wb_prio_e;

endpackage : regfile_pkg

// File: rtl/wb_prio_fsm.sv
// Writeback priority tracker: counts contested cycles lost by the execute stage
// and flips priority to it once the loss budget is spent.
module wb_prio_fsm
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT_P = STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic same_addr,
    input  logic grant0,
    output logic prefer0
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT_P);

    wb_prio_e   state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [4:0] cnt_inc;
    logic       contested;

    // Next-state and loss-counter update.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        contested    = req0_valid & req1_valid;
        cnt_inc      = {1'b0, starve_cnt_q} + 5'd1;

        if (grant0 || !req0_valid) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q == LIMIT_C) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = cnt_inc[3:0];
        end

        case (state_q)
            PRIO1: begin
                if (contested && !grant0 && (cnt_inc == {1'b0, LIMIT_C})) begin
                    state_d = PRIO0;
                end else begin
                    state_d = PRIO1;
                end
            end
            PRIO0: begin
                // A same-address loss leaves us here; only an actual grant releases priority.
                if (grant0) begin
                    state_d = PRIO1;
                end else begin
                    state_d = PRIO0;
                end
            end
            default: state_d = PRIO1;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PRIO1;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Program order outranks fairness: on a shared destination the older write goes first.
    assign prefer0 = (state_q == PRIO0) & ~same_addr;

endmodule : wb_prio_fsm

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the execute (req0) and
// memory (req1) writeback requesters, with a registered write port and a decode bypass.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int REG_SIZE_P     = REG_SIZE,
    parameter int ADDR_W_P       = ADDR_W,
    parameter int REG_NUMBER_P   = REG_NUMBER,
    parameter int STARVE_LIMIT_P = STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_W_P-1:0]   req0_addr,
    input  logic [REG_SIZE_P-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_W_P-1:0]   req1_addr,
    input  logic [REG_SIZE_P-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  Data_write1,
    output logic [ADDR_W_P-1:0]   write_addr1,
    output logic [REG_SIZE_P-1:0] write_data1,
    input  logic [ADDR_W_P-1:0]   byp_addr,
    output logic                  byp_hit,
    output logic [REG_SIZE_P-1:0] byp_data,
    output logic                  illegal_wr
);

    logic                  same_addr;
    logic                  prefer0;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  win_legal;
    logic [ADDR_W_P-1:0]   win_addr;
    logic [REG_SIZE_P-1:0] win_data;

    logic                  data_write1_q, data_write1_d;
    logic [ADDR_W_P-1:0]   write_addr1_q, write_addr1_d;
    logic [REG_SIZE_P-1:0] write_data1_q, write_data1_d;
    logic                  illegal_wr_q,  illegal_wr_d;

    assign same_addr = (req0_addr == req1_addr);

    wb_prio_fsm #(
        .STARVE_LIMIT_P (STARVE_LIMIT_P)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .same_addr  (same_addr),
        .grant0     (grant0),
        .prefer0    (prefer0)
    );

    // Grant mux: a lone requester always wins, contention follows the priority tracker.
    always_comb begin
        grant0    = ~rst & req0_valid & (~req1_valid | prefer0);
        grant1    = ~rst & req1_valid & (~req0_valid | ~prefer0);
        accept    = grant0 | grant1;
        if (grant0) begin
            win_addr = req0_addr;
            win_data = req0_data;
        end else begin
            win_addr = req1_addr;
            win_data = req1_data;
        end
        win_legal = ({1'b0, win_addr} < (ADDR_W_P + 1)'(REG_NUMBER_P));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Write-port load: illegal destinations consume the slot but never reach the register file.
    always_comb begin
        data_write1_d = accept & win_legal;
        illegal_wr_d  = accept & ~win_legal;
        write_addr1_d = write_addr1_q;
        write_data1_d = write_data1_q;
        if (accept && win_legal) begin
            write_addr1_d = win_addr;
            write_data1_d = win_data;
        end else begin
            write_addr1_d = write_addr1_q;
            write_data1_d = write_data1_q;
        end
    end

    // Write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_write1_q <= 1'b0;
            write_addr1_q <= '0;
            write_data1_q <= '0;
            illegal_wr_q  <= 1'b0;
        end else begin
            data_write1_q <= data_write1_d;
            write_addr1_q <= write_addr1_d;
            write_data1_q <= write_data1_d;
            illegal_wr_q  <= illegal_wr_d;
        end
    end

    assign Data_write1 = data_write1_q;
    assign write_addr1 = write_addr1_q;
    assign write_data1 = write_data1_q;
    assign illegal_wr  = illegal_wr_q;

    assign byp_hit  = data_write1_q & (write_addr1_q == byp_addr);
    assign byp_data = byp_hit ? write_data1_q : '0;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a behavioural arbitration model.
module tb_regfile_wb_arbiter;

    localparam int LIM  = 3;
    localparam int NREG = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr, byp_addr;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        Data_write1, byp_hit, illegal_wr;
    logic [3:0]  write_addr1;
    logic [15:0] write_data1, byp_data;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .Data_write1 (Data_write1),
        .write_addr1 (write_addr1),
        .write_data1 (write_data1),
        .byp_addr    (byp_addr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data),
        .illegal_wr  (illegal_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit wr;
        bit ill;
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    // reference model state: contested cycles lost in a row, and whether req0 is owed a win
    int   lost   = 0;
    bit   forced = 1'b0;
    bit   acc0   = 1'b0;
    bit   acc1   = 1'b0;
    int   last_addr = 0;

    // stimulus shaping
    int   p0 = 50, p1 = 50;
    int   lo0 = 0, hi0 = 9, lo1 = 0, hi1 = 9;
    int   rst_pct = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_cycle(input bit r);
        bit g0, g1, both;
        @(negedge clk);
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        rst = r;
        if (!req0_valid && $urandom_range(99, 0) < p0) begin
            req0_valid = 1'b1;
            req0_addr  = 4'($urandom_range(hi0, lo0));
            req0_data  = 16'($urandom);
        end
        if (!req1_valid && $urandom_range(99, 0) < p1) begin
            req1_valid = 1'b1;
            req1_addr  = 4'($urandom_range(hi1, lo1));
            req1_data  = 16'($urandom);
        end
        byp_addr = ($urandom_range(3, 0) != 0) ? 4'(last_addr) : 4'($urandom_range(15, 0));
        #2;
        both = req0_valid && req1_valid;
        if (r) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end else if (both) begin
            g0 = (req0_addr != req1_addr) && forced;
            g1 = !g0;
        end else begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        if (g0 || g1) begin
            exp_t e;
            e.due  = cyc + 1;
            e.addr = g0 ? int'(req0_addr) : int'(req1_addr);
            e.data = g0 ? int'(req0_data) : int'(req1_data);
            e.wr   = (e.addr < NREG);
            e.ill  = !e.wr;
            if (e.wr) last_addr = e.addr;
            q.push_back(e);
        end
        if (r || g0) begin
            lost   = 0;
            forced = 1'b0;
        end else if (req0_valid) begin
            if (lost < LIM) lost++;
            if (both && lost == LIM) forced = 1'b1;
        end else begin
            lost = 0;
        end
        acc0 = g0;
        acc1 = g1;
        @(posedge clk);
        #1;
    endtask

    // monitor: compares the registered write port and bypass against the scoreboard each cycle
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                exp_t e;
                bit   hit;
                e = '{due: 0, wr: 1'b0, ill: 1'b0, addr: 0, data: 0};
                if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
                check("Data_write1", Data_write1, e.wr);
                check("illegal_wr", illegal_wr, e.ill);
                if (e.wr) begin
                    check("write_addr1", write_addr1, e.addr);
                    check("write_data1", write_data1, e.data);
                end
                hit = e.wr && (e.addr == int'(byp_addr));
                check("byp_hit", byp_hit, hit);
                check("byp_data", byp_data, hit ? e.data : 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 4'd0;  req1_addr = 4'd0;
        req0_data = 16'd0; req1_data = 16'd0;
        byp_addr = 4'd0;

        // reset held with both requesters pending
        p0 = 100; p1 = 100;
        do_cycle(1'b1);
        mon_en = 1'b1;
        do_cycle(1'b1);

        // lone execute-stage write, then lone illegal memory-stage write
        acc0 = 1'b0; acc1 = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'hBEEF;
        req1_valid = 1'b0;
        p0 = 0; p1 = 0;
        do_cycle(1'b0);
        req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 16'h1234;
        do_cycle(1'b0);
        do_cycle(1'b0);
        do_cycle(1'b0);

        // sustained contention, distinct destinations
        p0 = 100; p1 = 100; lo0 = 0; hi0 = 3; lo1 = 4; hi1 = 7;
        repeat (24) do_cycle(1'b0);

        // sustained contention on one destination
        lo0 = 4; hi0 = 4; lo1 = 4; hi1 = 4;
        repeat (12) do_cycle(1'b0);

        // mixed random traffic with illegal addresses and occasional resets
        p0 = 60; p1 = 60; lo0 = 0; hi0 = 11; lo1 = 0; hi1 = 11;
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(99, 0) < 3);
        end

        // drain
        p0 = 0; p1 = 0;
        repeat (6) do_cycle(1'b0);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
